// File: rtl/reg_window_pkg.sv
// Shared types and constants for the register-window frame-pointer sequencer.
package reg_window_pkg;

   localparam int WIN      = 8;
   localparam int NUM_PHYS = 16;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      FAULT
   } win_state_t;

   typedef enum logic [1:0] {
      FC_NONE = 2'b00,
      FC_OVF  = 2'b01,
      FC_UDF  = 2'b10,
      FC_ILL  = 2'b11
   } fault_code_t;

endpackage

// File: rtl/offset_lifo.sv
// LIFO of CALL offsets; the top entry is visible combinationally for RTN.
module offset_lifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = $clog2(DEPTH + 1)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          push,
   input  logic          pop,
   input  logic [2:0]    din,
   output logic [2:0]    dout,
   output logic          full,
   output logic          empty,
   output logic [DW-1:0] depth
);

   logic [2:0]    mem [DEPTH];
   logic [DW-1:0] sp;

   assign full  = (sp == DW'(DEPTH));
   assign empty = (sp == '0);
   assign depth = sp;
   assign dout  = mem[AW'(sp - 1'b1)];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + 1'b1;
      end else if (pop && !empty) begin
         sp <= sp - 1'b1;
      end
   end

   // Storage needs no reset: only entries below sp are ever read.
   always_ff @(posedge Clock) begin
      if (!Reset && push && !full) begin
         mem[AW'(sp)] <= din;
      end
   end

endmodule

// File: rtl/reg_window_ctrl.sv
// Frame-pointer sequencer: operand address map plus CALL/RTN window moves.
module reg_window_ctrl
   import reg_window_pkg::*;
#(
   parameter int STACK_DEPTH = 8
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       call_req,
   input  logic       rtn_req,
   input  logic [2:0] call_off,
   output logic       ready,
   input  logic [2:0] Actual_Rd,
   input  logic [2:0] Actual_Rs,
   input  logic [2:0] Actual_Rm,
   input  logic       wen_rd,
   input  logic       wen_rs,
   output logic [3:0] Rd_Addr,
   output logic [3:0] Rs_Addr,
   output logic [3:0] Rm_Addr,
   output logic       Rd_Wen,
   output logic       Rs_Wen,
   output logic [2:0] Actual_Rs_o,
   output logic [3:0] New_FP,
   output logic       FP_move,
   output logic       FP_push_up,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [3:0] depth
);

   localparam int DW = $clog2(STACK_DEPTH + 1);

   win_state_t  state, state_n;
   fault_code_t code, code_n;
   logic [3:0]  fp, fp_n;
   logic [3:0]  target, target_n;
   logic [2:0]  mv_off, mv_off_n;
   logic        mv_up, mv_up_n;

   logic          push, pop;
   logic [2:0]    lifo_top;
   logic          lifo_full, lifo_empty;
   logic [DW-1:0] lifo_depth;
   logic [4:0]    call_end;

   offset_lifo #(.DEPTH(STACK_DEPTH)) u_lifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push),
      .pop   (pop),
      .din   (call_off),
      .dout  (lifo_top),
      .full  (lifo_full),
      .empty (lifo_empty),
      .depth (lifo_depth)
   );

   // Highest physical register the new window would touch.
   assign call_end = {1'b0, fp} + {2'b00, call_off} + 5'(WIN - 1);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= IDLE;
         code   <= FC_NONE;
         fp     <= '0;
         target <= '0;
         mv_off <= '0;
         mv_up  <= 1'b0;
      end else begin
         state  <= state_n;
         code   <= code_n;
         fp     <= fp_n;
         target <= target_n;
         mv_off <= mv_off_n;
         mv_up  <= mv_up_n;
      end
   end

   always_comb begin
      state_n  = state;
      code_n   = code;
      fp_n     = fp;
      target_n = target;
      mv_off_n = mv_off;
      mv_up_n  = mv_up;
      push     = 1'b0;
      pop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (call_req && rtn_req) begin
               state_n = FAULT;
               code_n  = FC_ILL;
            end else if (call_req) begin
               if (call_off == 3'd0) begin
                  state_n = FAULT;
                  code_n  = FC_ILL;
               end else if (call_end > 5'(NUM_PHYS - 1) || lifo_full) begin
                  state_n = FAULT;
                  code_n  = FC_OVF;
               end else begin
                  push     = 1'b1;
                  target_n = fp + {1'b0, call_off};
                  mv_off_n = call_off;
                  mv_up_n  = 1'b1;
                  state_n  = MOVE;
               end
            end else if (rtn_req) begin
               if (lifo_empty) begin
                  state_n = FAULT;
                  code_n  = FC_UDF;
               end else begin
                  pop      = 1'b1;
                  target_n = fp - {1'b0, lifo_top};
                  mv_off_n = lifo_top;
                  mv_up_n  = 1'b0;
                  state_n  = MOVE;
               end
            end
         end
         MOVE: begin
            fp_n    = target;
            state_n = IDLE;
         end
         FAULT: begin
            state_n = FAULT;
         end
         default: begin
            state_n = FAULT;
            code_n  = FC_ILL;
         end
      endcase
   end

   // During MOVE addresses still use the old FP, so a link write hits the caller frame.
   assign Rd_Addr = fp + {1'b0, Actual_Rd};
   assign Rs_Addr = fp + {1'b0, Actual_Rs};
   assign Rm_Addr = fp + {1'b0, Actual_Rm};

   assign Rd_Wen      = wen_rd && (state != FAULT);
   assign Rs_Wen      = wen_rs && (state != FAULT);
   assign ready       = (state == IDLE);
   assign FP_move     = (state == MOVE);
   assign FP_push_up  = (state == MOVE) && mv_up;
   assign New_FP      = (state == MOVE) ? target : fp;
   assign Actual_Rs_o = (state == MOVE) ? mv_off : Actual_Rs;
   assign fault       = (state == FAULT);
   assign fault_code  = code;
   assign depth       = 4'(lifo_depth);

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Directed, table-driven bench for reg_window_ctrl.
module tb_reg_window_ctrl;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       call_req, rtn_req;
   logic [2:0] call_off;
   logic       ready;
   logic [2:0] Actual_Rd, Actual_Rs, Actual_Rm;
   logic       wen_rd, wen_rs;
   logic [3:0] Rd_Addr, Rs_Addr, Rm_Addr;
   logic       Rd_Wen, Rs_Wen;
   logic [2:0] Actual_Rs_o;
   logic [3:0] New_FP;
   logic       FP_move, FP_push_up, fault;
   logic [1:0] fault_code;
   logic [3:0] depth;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 Clock = ~Clock;

   reg_window_ctrl dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .call_req    (call_req),
      .rtn_req     (rtn_req),
      .call_off    (call_off),
      .ready       (ready),
      .Actual_Rd   (Actual_Rd),
      .Actual_Rs   (Actual_Rs),
      .Actual_Rm   (Actual_Rm),
      .wen_rd      (wen_rd),
      .wen_rs      (wen_rs),
      .Rd_Addr     (Rd_Addr),
      .Rs_Addr     (Rs_Addr),
      .Rm_Addr     (Rm_Addr),
      .Rd_Wen      (Rd_Wen),
      .Rs_Wen      (Rs_Wen),
      .Actual_Rs_o (Actual_Rs_o),
      .New_FP      (New_FP),
      .FP_move     (FP_move),
      .FP_push_up  (FP_push_up),
      .fault       (fault),
      .fault_code  (fault_code),
      .depth       (depth)
   );

   typedef struct {
      logic [2:0] rd, rs, rm;
      logic       wd, ws;
      logic [3:0] e_rd, e_rs, e_rm;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      call_req = 1'b0;
      rtn_req  = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   // One request cycle; returns positioned in the following (MOVE) cycle.
   task automatic req(input logic c, input logic r, input logic [2:0] off);
      call_req = c;
      rtn_req  = r;
      call_off = off;
      tick();
      call_req = 1'b0;
      rtn_req  = 1'b0;
   endtask

   task automatic apply_vec(input int i);
      Actual_Rd = tbl[i].rd;
      Actual_Rs = tbl[i].rs;
      Actual_Rm = tbl[i].rm;
      wen_rd    = tbl[i].wd;
      wen_rs    = tbl[i].ws;
      #1;
      check($sformatf("vec%0d Rd_Addr", i), Rd_Addr, tbl[i].e_rd);
      check($sformatf("vec%0d Rs_Addr", i), Rs_Addr, tbl[i].e_rs);
      check($sformatf("vec%0d Rm_Addr", i), Rm_Addr, tbl[i].e_rm);
      check($sformatf("vec%0d Rd_Wen", i), Rd_Wen, tbl[i].wd);
      check($sformatf("vec%0d Rs_Wen", i), Rs_Wen, tbl[i].ws);
      check($sformatf("vec%0d Rs_o", i), Actual_Rs_o, tbl[i].rs);
   endtask

   initial begin
      // FP = 0 vectors
      tbl[0] = '{3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 4'd5, 4'd1, 4'd2};
      tbl[1] = '{3'd0, 3'd7, 3'd3, 1'b0, 1'b1, 4'd0, 4'd7, 4'd3};
      tbl[2] = '{3'd7, 3'd7, 3'd7, 1'b1, 1'b1, 4'd7, 4'd7, 4'd7};
      // FP = 3 vectors
      tbl[3] = '{3'd4, 3'd0, 3'd7, 1'b1, 1'b1, 4'd7, 4'd3, 4'd10};
      tbl[4] = '{3'd2, 3'd6, 3'd1, 1'b0, 1'b0, 4'd5, 4'd9, 4'd4};
      // FP = 8 vectors (topmost window)
      tbl[5] = '{3'd7, 3'd0, 3'd3, 1'b1, 1'b0, 4'd15, 4'd8, 4'd11};
      tbl[6] = '{3'd1, 3'd7, 3'd7, 1'b0, 1'b1, 4'd9, 4'd15, 4'd15};

      call_off  = 3'd0;
      Actual_Rd = 3'd0;
      Actual_Rs = 3'd0;
      Actual_Rm = 3'd0;
      wen_rd    = 1'b0;
      wen_rs    = 1'b0;
      do_reset();

      check("rst ready", ready, 1);
      check("rst depth", depth, 0);
      check("rst fault", fault, 0);
      check("rst code", fault_code, 0);
      check("rst FP_move", FP_move, 0);
      check("rst push_up", FP_push_up, 0);
      check("rst New_FP", New_FP, 0);

      for (int i = 0; i < 3; i++) apply_vec(i);

      // CALL 3 from FP=0
      Actual_Rd = 3'd5;
      Actual_Rs = 3'd6;
      req(1'b1, 1'b0, 3'd3);
      check("call3 FP_move", FP_move, 1);
      check("call3 push_up", FP_push_up, 1);
      check("call3 New_FP", New_FP, 3);
      check("call3 Rs_o", Actual_Rs_o, 3);
      check("call3 ready", ready, 0);
      check("call3 link Rd", Rd_Addr, 5);
      tick();
      Actual_Rd = 3'd2;
      #1;
      check("call3 after Rd", Rd_Addr, 5);
      check("call3 depth", depth, 1);
      check("call3 strobe off", FP_move, 0);
      check("call3 New_FP idle", New_FP, 3);

      for (int i = 3; i < 5; i++) apply_vec(i);

      // CALL 4 -> FP=7
      req(1'b1, 1'b0, 3'd4);
      check("call4 New_FP", New_FP, 7);
      check("call4 Rs_o", Actual_Rs_o, 4);
      tick();
      check("call4 depth", depth, 2);

      // RTN -> FP=3
      req(1'b0, 1'b1, 3'd0);
      check("rtn1 FP_move", FP_move, 1);
      check("rtn1 New_FP", New_FP, 3);
      check("rtn1 push_up", FP_push_up, 0);
      check("rtn1 Rs_o", Actual_Rs_o, 4);
      tick();
      check("rtn1 depth", depth, 1);

      // RTN -> FP=0
      req(1'b0, 1'b1, 3'd0);
      check("rtn2 New_FP", New_FP, 0);
      check("rtn2 Rs_o", Actual_Rs_o, 3);
      tick();
      Actual_Rd = 3'd5;
      #1;
      check("rtn2 depth", depth, 0);
      check("rtn2 Rd", Rd_Addr, 5);

      // Underflow
      req(1'b0, 1'b1, 3'd0);
      check("udf fault", fault, 1);
      check("udf code", fault_code, 2);
      check("udf ready", ready, 0);
      req(1'b1, 1'b0, 3'd1);
      check("udf ignore move", FP_move, 0);
      check("udf sticky code", fault_code, 2);
      check("udf depth", depth, 0);
      do_reset();
      check("udf cleared", fault, 0);

      // Overflow by NUM_PHYS: FP=7, CALL 2
      req(1'b1, 1'b0, 3'd3);
      tick();
      req(1'b1, 1'b0, 3'd4);
      tick();
      wen_rd    = 1'b1;
      wen_rs    = 1'b1;
      Actual_Rd = 3'd1;
      req(1'b1, 1'b0, 3'd2);
      check("ovf fault", fault, 1);
      check("ovf code", fault_code, 1);
      check("ovf FP", New_FP, 7);
      check("ovf Rd_Wen", Rd_Wen, 0);
      check("ovf Rs_Wen", Rs_Wen, 0);
      check("ovf ready", ready, 0);
      check("ovf Rd addr", Rd_Addr, 8);
      req(1'b0, 1'b1, 3'd0);
      tick();
      check("ovf ignore rtn", FP_move, 0);
      check("ovf depth frozen", depth, 2);
      check("ovf FP frozen", New_FP, 7);
      check("ovf code sticky", fault_code, 1);
      do_reset();

      // Simultaneous requests
      req(1'b1, 1'b1, 3'd2);
      check("ill both code", fault_code, 3);
      check("ill both depth", depth, 0);
      check("ill both move", FP_move, 0);
      do_reset();

      // Zero offset
      req(1'b1, 1'b0, 3'd0);
      check("ill off0 code", fault_code, 3);
      check("ill off0 fault", fault, 1);
      do_reset();

      // Eight CALL 1s reach FP=8, depth 8; ninth overflows
      for (int k = 0; k < 8; k++) begin
         req(1'b1, 1'b0, 3'd1);
         check($sformatf("deep%0d New_FP", k), New_FP, k + 1);
         tick();
      end
      check("deep depth", depth, 8);
      check("deep ready", ready, 1);
      for (int i = 5; i < 7; i++) apply_vec(i);
      req(1'b1, 1'b0, 3'd1);
      check("deep ovf code", fault_code, 1);
      check("deep ovf depth", depth, 8);
      do_reset();

      // Reset during MOVE
      req(1'b1, 1'b0, 3'd3);
      check("rstmv strobe", FP_move, 1);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("rstmv FP", New_FP, 0);
      check("rstmv depth", depth, 0);
      check("rstmv move", FP_move, 0);
      check("rstmv fault", fault, 0);
      check("rstmv ready", ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
